// File: rtl/data_memory_ctrl_if.sv
// Load/store bus between the LSU/MEM stage and data_memory_ctrl.
interface data_memory_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, size, unsigned_ld, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with RISC-V style sized loads/stores,
// registered read, error reporting and a post-reset init sequencer.
module data_memory_ctrl #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DEPTH_BYTES  = 256,
  parameter int unsigned ADDR_W       = 64,
  parameter bit          INIT_PATTERN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_ctrl_if.slave bus
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned ROWS   = DEPTH_BYTES / LANES;
  localparam int unsigned CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned IDX_W  = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [7:0]          mem_q [DEPTH_BYTES];

  logic [ADDR_W:0]     nbytes_x;
  logic [ADDR_W:0]     end_x;
  logic                size_bad, misalign, out_range, bad, accept;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   raw, ld_data;
  logic                sign, fill;
  int unsigned         nbits, nb;
  logic [LANES-1:0]    wr_en;
  logic [IDX_W-1:0]    wr_base;
  logic [DATA_W-1:0]   wr_data;

  // Access decode: size, alignment and carry-aware range legality.
  always_comb begin
    nbytes_x = '0;
    nbytes_x[bus.size] = 1'b1;
    size_bad  = (bus.size == 2'd3) && (LANES < 8);
    misalign  = |(bus.addr & (nbytes_x[ADDR_W-1:0] - ADDR_W'(1)));
    end_x     = {1'b0, bus.addr} + nbytes_x;
    out_range = end_x > DEPTH_X;
    bad       = size_bad | misalign | out_range;
    idx       = bus.addr[IDX_W-1:0];
    accept    = ready_q & bus.req;
  end

  // Load path: gather little-endian bytes, then sign/zero extend.
  always_comb begin
    raw = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      raw[l*8 +: 8] = mem_q[idx + IDX_W'(l)];
    end
    case (bus.size)
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[DATA_W-1];
    endcase
    fill  = sign & ~bus.unsigned_ld;
    nbits = 32'd8 << bus.size;
    ld_data = '0;
    for (int unsigned b = 0; b < DATA_W; b++) begin
      ld_data[b] = (b < nbits) ? raw[b] : fill;
    end
  end

  // Write path: whole row per cycle during init, sized store lanes in run.
  always_comb begin
    wr_en   = '0;
    wr_base = idx;
    wr_data = bus.wdata;
    nb      = 32'd1 << bus.size;
    if (state_q == ST_INIT) begin
      wr_en   = '1;
      wr_base = IDX_W'(cnt_q) << LANE_W;
      for (int unsigned l = 0; l < LANES; l++) begin
        wr_data[l*8 +: 8] = INIT_PATTERN ? 8'(wr_base + IDX_W'(l)) : 8'h00;
      end
    end else if (accept && bus.we && !bad) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        wr_en[l] = (l < nb);
      end
    end
  end

  // Byte storage; contents are rebuilt by the init sequencer so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < LANES; l++) begin
      if (wr_en[l]) mem_q[wr_base + IDX_W'(l)] <= wr_data[l*8 +: 8];
    end
  end

  // Next-state and response computation for the INIT/RUN sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        ready_d = 1'b1;
        if (accept) begin
          if (bad) begin
            err_d    = 1'b1;
            rvalid_d = ~bus.we;
            rdata_d  = '0;
          end else if (!bus.we) begin
            rvalid_d = 1'b1;
            rdata_d  = ld_data;
          end
        end
      end
    endcase
  end

  // State and registered outputs; async active-low reset restarts init.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;

endmodule
